// File: rtl/scalar_shift_mask.sv
// Scalar shift / mask-forming unit: turns a bit count back into a 64-bit S word.
// Ones masks (042/043), single shifts (052-055), and double shifts (056/057).
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   i_issue        instruction issued this cycle
//   i_instr        opcode gh (octal 042, 043, 052-057)
//   i_i            i designator (destination / shifted operand Si)
//   i_jk           jk field: shift or mask count
//   i_si, i_sj     (Si), (Sj) operands (Sj used by 056/057 only)
//   i_ak           (Ak) double-shift count (056/057 only)
//   o_valid        result valid this cycle
//   o_result       result word (holds while o_valid=0)
//   o_dest         destination S index (holds while o_valid=0)
//   o_collide      double shift and single op completed together
//
// Configuration macro: CRAY_SCALAR_DOUBLE_SHIFT_EN
//   defined   -> 056/057 decoded, stage 3 and collision detection built
//   undefined -> 056/057 launch nothing, o_collide tied 0

module scalar_shift_mask (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_issue,
   input  logic [6:0]  i_instr,
   input  logic [2:0]  i_i,
   input  logic [5:0]  i_jk,
   input  logic [63:0] i_si,
   input  logic [63:0] i_sj,
   input  logic [23:0] i_ak,
   output logic        o_valid,
   output logic [63:0] o_result,
   output logic [2:0]  o_dest,
   output logic        o_collide
);

   localparam logic [63:0] c_ONES = '1;

   typedef enum logic [2:0] {
      OP_MLO,
      OP_MHI,
      OP_SHL,
      OP_SHR,
      OP_DSL,
      OP_DSR
   } op_t;

   // ------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------
   logic       w_dec_vld;
   logic       w_dec_dbl;
   op_t        w_dec_op;
   logic [6:0] w_dec_cnt;
   logic [2:0] w_dec_dest;

   // Right shifts by (64 - jk) are done in 7 bits so jk=0 gives
   // exactly 64, which shifts everything out.
   logic [6:0] w_jk7;
   logic [6:0] w_jk_inv;

   assign w_jk7    = {1'b0, i_jk};
   assign w_jk_inv = 7'd64 - w_jk7;

   always_comb begin
      w_dec_vld  = 1'b0;
      w_dec_dbl  = 1'b0;
      w_dec_op   = OP_MLO;
      w_dec_cnt  = w_jk7;
      w_dec_dest = i_i;
      case (i_instr)
         7'o042: begin
            w_dec_vld = i_issue;
            w_dec_op  = OP_MLO;
         end
         7'o043: begin
            w_dec_vld = i_issue;
            w_dec_op  = OP_MHI;
         end
         7'o052: begin
            w_dec_vld  = i_issue;
            w_dec_op   = OP_SHL;
            w_dec_dest = 3'd0;
         end
         7'o053: begin
            w_dec_vld  = i_issue;
            w_dec_op   = OP_SHR;
            w_dec_cnt  = w_jk_inv;
            w_dec_dest = 3'd0;
         end
         7'o054: begin
            w_dec_vld = i_issue;
            w_dec_op  = OP_SHL;
         end
         7'o055: begin
            w_dec_vld = i_issue;
            w_dec_op  = OP_SHR;
            w_dec_cnt = w_jk_inv;
         end
`ifdef CRAY_SCALAR_DOUBLE_SHIFT_EN
         7'o056: begin
            w_dec_vld = i_issue;
            w_dec_dbl = 1'b1;
            w_dec_op  = OP_DSL;
         end
         7'o057: begin
            w_dec_vld = i_issue;
            w_dec_dbl = 1'b1;
            w_dec_op  = OP_DSR;
         end
`endif
         default: begin
            w_dec_vld = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Stage 1: registered decode and operands
   // ------------------------------------------------------------
   logic        r_s1_vld;
   op_t         r_s1_op;
   logic [6:0]  r_s1_cnt;
   logic [63:0] r_s1_si;
   logic [2:0]  r_s1_dest;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_op   <= OP_MLO;
         r_s1_cnt  <= '0;
         r_s1_si   <= '0;
         r_s1_dest <= '0;
      end else begin
         r_s1_vld <= w_dec_vld & ~w_dec_dbl;
         if (w_dec_vld) begin
            r_s1_op   <= w_dec_op;
            r_s1_cnt  <= w_dec_cnt;
            r_s1_si   <= i_si;
            r_s1_dest <= w_dec_dest;
         end
      end
   end

   // ------------------------------------------------------------
   // Stage 2: mask forming / single shift
   // ------------------------------------------------------------
   logic [63:0] w_s2_res;

   always_comb begin
      w_s2_res = '0;
      case (r_s1_op)
         OP_MLO:  w_s2_res = c_ONES >> r_s1_cnt;
         OP_MHI:  w_s2_res = ~(c_ONES >> r_s1_cnt);
         OP_SHL:  w_s2_res = r_s1_si << r_s1_cnt;
         OP_SHR:  w_s2_res = r_s1_si >> r_s1_cnt;
         default: w_s2_res = '0;
      endcase
   end

   // ------------------------------------------------------------
   // Double-shift path (stages 2 and 3)
   // ------------------------------------------------------------
   logic        w_s3_vld;
   logic [63:0] w_s3_res;
   logic [2:0]  w_s3_dest;

`ifdef CRAY_SCALAR_DOUBLE_SHIFT_EN
   logic        r_s1_dvld;
   logic [63:0] r_s1_sj;
   logic [23:0] r_s1_ak;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_dvld <= 1'b0;
         r_s1_sj   <= '0;
         r_s1_ak   <= '0;
      end else begin
         r_s1_dvld <= w_dec_vld & w_dec_dbl;
         if (w_dec_vld & w_dec_dbl) begin
            r_s1_sj <= i_sj;
            r_s1_ak <= i_ak;
         end
      end
   end

   // Left shift keeps the high half of {Si,Sj}; right shift keeps the
   // low half of {Sj,Si}. Any count of 128 or more clears the word.
   logic         w_s2_left;
   logic         w_s2_big;
   logic [127:0] w_s2_pair;
   logic [127:0] w_s2_wide;

   assign w_s2_left = (r_s1_op == OP_DSL);
   assign w_s2_big  = |r_s1_ak[23:7];
   assign w_s2_pair = w_s2_left ? {r_s1_si, r_s1_sj}
                                : {r_s1_sj, r_s1_si};
   assign w_s2_wide = w_s2_left ? (w_s2_pair << r_s1_ak[6:0])
                                : (w_s2_pair >> r_s1_ak[6:0]);

   logic         r_s2_vld;
   logic         r_s2_left;
   logic         r_s2_zero;
   logic [127:0] r_s2_wide;
   logic [2:0]   r_s2_dest;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld  <= 1'b0;
         r_s2_left <= 1'b0;
         r_s2_zero <= 1'b0;
         r_s2_wide <= '0;
         r_s2_dest <= '0;
      end else begin
         r_s2_vld <= r_s1_dvld;
         if (r_s1_dvld) begin
            r_s2_left <= w_s2_left;
            r_s2_zero <= w_s2_big;
            r_s2_wide <= w_s2_wide;
            r_s2_dest <= r_s1_dest;
         end
      end
   end

   always_comb begin
      w_s3_vld  = r_s2_vld;
      w_s3_dest = r_s2_dest;
      if (r_s2_zero) begin
         w_s3_res = '0;
      end else if (r_s2_left) begin
         w_s3_res = r_s2_wide[127:64];
      end else begin
         w_s3_res = r_s2_wide[63:0];
      end
   end
`else
   logic w_unused_dbl;

   assign w_unused_dbl = ^{i_sj, i_ak, w_dec_dbl};
   assign w_s3_vld     = 1'b0;
   assign w_s3_res     = '0;
   assign w_s3_dest    = '0;
`endif

   // ------------------------------------------------------------
   // Completion and output registers
   // ------------------------------------------------------------
   // The older double shift wins the write port; a single op finishing
   // in the same cycle is dropped and flagged.
   logic        w_fin_vld;
   logic [63:0] w_fin_res;
   logic [2:0]  w_fin_dest;
   logic        w_collide;

   assign w_fin_vld  = w_s3_vld | r_s1_vld;
   assign w_fin_res  = w_s3_vld ? w_s3_res  : w_s2_res;
   assign w_fin_dest = w_s3_vld ? w_s3_dest : r_s1_dest;
   assign w_collide  = w_s3_vld & r_s1_vld;

   logic        r_valid;
   logic [63:0] r_result;
   logic [2:0]  r_dest;
   logic        r_collide;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_result  <= '0;
         r_dest    <= '0;
         r_collide <= 1'b0;
      end else begin
         r_valid   <= w_fin_vld;
         r_collide <= w_collide;
         if (w_fin_vld) begin
            r_result <= w_fin_res;
            r_dest   <= w_fin_dest;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_result  = r_result;
   assign o_dest    = r_dest;
   assign o_collide = r_collide;

endmodule

// File: tb/tb_scalar_shift_mask.sv
// Bench for scalar_shift_mask: directed literal cases plus random traffic
// checked every cycle against a completion-schedule model.

module tb_scalar_shift_mask;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_issue = 1'b0;
   logic [6:0]  i_instr = '0;
   logic [2:0]  i_i = '0;
   logic [5:0]  i_jk = '0;
   logic [63:0] i_si = '0;
   logic [63:0] i_sj = '0;
   logic [23:0] i_ak = '0;
   logic        o_valid;
   logic [63:0] o_result;
   logic [2:0]  o_dest;
   logic        o_collide;

   int total = 0;
   int bad = 0;

   scalar_shift_mask dut (
      .clk       (clk),
      .rst       (rst),
      .i_issue   (i_issue),
      .i_instr   (i_instr),
      .i_i       (i_i),
      .i_jk      (i_jk),
      .i_si      (i_si),
      .i_sj      (i_sj),
      .i_ak      (i_ak),
      .o_valid   (o_valid),
      .o_result  (o_result),
      .o_dest    (o_dest),
      .o_collide (o_collide)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------
   // Model: each accepted op is placed in the cycle it completes.
   // ------------------------------------------------------------
   int          cyc = 0;
   bit          m_init = 0;
   bit          m_v = 0;
   bit          m_c = 0;
   logic [63:0] m_r = '0;
   logic [2:0]  m_d = '0;
   bit          pend_v[int];
   bit          pend_c[int];
   logic [63:0] pend_r[int];
   logic [2:0]  pend_d[int];

   task automatic model_issue();
      logic [127:0] t;
      logic [63:0]  r;
      logic [2:0]   d;
      int           lat;
      int           n;
      int           slot;
      bit           ok;
      ok  = 1;
      lat = 1;
      d   = i_i;
      r   = '0;
      n   = 64 - int'(i_jk);
      case (i_instr)
         7'o042: begin t = (128'd1 << n) - 128'd1; r = t[63:0]; end
         7'o043: begin t = (128'd1 << n) - 128'd1; r = ~t[63:0]; end
         7'o052: begin t = {64'd0, i_si} << i_jk; r = t[63:0]; d = 0; end
         7'o053: begin t = {64'd0, i_si} >> n; r = t[63:0]; d = 0; end
         7'o054: begin t = {64'd0, i_si} << i_jk; r = t[63:0]; end
         7'o055: begin t = {64'd0, i_si} >> n; r = t[63:0]; end
`ifdef CRAY_SCALAR_DOUBLE_SHIFT_EN
         7'o056: begin
            lat = 2;
            if (i_ak >= 24'd128) r = '0;
            else begin t = {i_si, i_sj} << i_ak; r = t[127:64]; end
         end
         7'o057: begin
            lat = 2;
            if (i_ak >= 24'd128) r = '0;
            else begin t = {i_sj, i_si} >> i_ak; r = t[63:0]; end
         end
`endif
         default: ok = 0;
      endcase
      if (ok) begin
         slot = cyc + lat;
         if (pend_v.exists(slot)) begin
            pend_c[slot] = 1;
         end else begin
            pend_v[slot] = 1;
            pend_r[slot] = r;
            pend_d[slot] = d;
            pend_c[slot] = 0;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         pend_v.delete();
         pend_c.delete();
         pend_r.delete();
         pend_d.delete();
         m_v = 0;
         m_c = 0;
         m_r = '0;
         m_d = '0;
         m_init = 1;
      end else begin
         if (pend_v.exists(cyc)) begin
            m_v = 1;
            m_r = pend_r[cyc];
            m_d = pend_d[cyc];
            m_c = pend_c[cyc];
            pend_v.delete(cyc);
            pend_c.delete(cyc);
            pend_r.delete(cyc);
            pend_d.delete(cyc);
         end else begin
            m_v = 0;
            m_c = 0;
         end
         if (i_issue) model_issue();
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_init) begin
         chk("m_valid", {63'd0, o_valid}, {63'd0, m_v});
         chk("m_collide", {63'd0, o_collide}, {63'd0, m_c});
         chk("m_result", o_result, m_r);
         chk("m_dest", {61'd0, o_dest}, {61'd0, m_d});
      end
   end

   // ------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------
   task automatic iss(input logic [6:0] op, input logic [2:0] ii,
                      input logic [5:0] jk, input logic [63:0] si,
                      input logic [63:0] sj, input logic [23:0] ak);
      i_issue = 1'b1;
      i_instr = op;
      i_i     = ii;
      i_jk    = jk;
      i_si    = si;
      i_sj    = sj;
      i_ak    = ak;
      @(negedge clk);
      i_issue = 1'b0;
   endtask

   task automatic expv(input string nm, input logic v,
                       input logic [63:0] r, input logic [2:0] d);
      chk({nm, "_v"}, {63'd0, o_valid}, {63'd0, v});
      if (v) begin
         chk({nm, "_r"}, o_result, r);
         chk({nm, "_d"}, {61'd0, o_dest}, {61'd0, d});
      end
   endtask

   logic [6:0] ops [10] = '{7'o042, 7'o043, 7'o052, 7'o053, 7'o054,
                            7'o055, 7'o056, 7'o057, 7'o044, 7'o000};

   initial begin
      logic [63:0] si_pat;
      si_pat = 64'h0123_4567_89AB_CDEF;
      repeat (3) @(negedge clk);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_result", o_result, 64'd0);
      chk("rst_dest", {61'd0, o_dest}, 64'd0);
      chk("rst_collide", {63'd0, o_collide}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      iss(7'o043, 3'd5, 6'd8, '0, '0, '0);
      @(negedge clk);
      expv("m043_8", 1'b1, 64'hFF00_0000_0000_0000, 3'd5);

      iss(7'o042, 3'd1, 6'd0, '0, '0, '0);
      iss(7'o042, 3'd2, 6'd63, '0, '0, '0);
      expv("m042_0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
      @(negedge clk);
      expv("m042_63", 1'b1, 64'h1, 3'd2);
      @(negedge clk);
      expv("idle", 1'b0, '0, '0);

      iss(7'o052, 3'd3, 6'd4, 64'h8000_0000_0000_0001, '0, '0);
      @(negedge clk);
      expv("s052", 1'b1, 64'h10, 3'd0);
      iss(7'o055, 3'd2, 6'd60, 64'hF0, '0, '0);
      @(negedge clk);
      expv("s055", 1'b1, 64'h0F, 3'd2);
      iss(7'o053, 3'd4, 6'd0, 64'hFFFF_0000_FFFF_0000, '0, '0);
      @(negedge clk);
      expv("s053_0", 1'b1, 64'h0, 3'd0);

`ifdef CRAY_SCALAR_DOUBLE_SHIFT_EN
      iss(7'o056, 3'd6, '0, si_pat, 64'hF000_0000_0000_0000, 24'd4);
      @(negedge clk);
      expv("d056_early", 1'b0, '0, '0);
      @(negedge clk);
      expv("d056_4", 1'b1, 64'h1234_5678_9ABC_DEFF, 3'd6);
      iss(7'o056, 3'd6, '0, si_pat, 64'hF000_0000_0000_0000, 24'd0);
      repeat (2) @(negedge clk);
      expv("d056_0", 1'b1, si_pat, 3'd6);
      iss(7'o056, 3'd7, '0, si_pat, 64'hF000_0000_0000_0000, 24'd128);
      repeat (2) @(negedge clk);
      expv("d056_128", 1'b1, 64'h0, 3'd7);
      iss(7'o057, 3'd1, '0, 64'h1, 64'h0, 24'd1);
      repeat (2) @(negedge clk);
      expv("d057_1", 1'b1, 64'h0, 3'd1);

      iss(7'o056, 3'd3, '0, si_pat, 64'hF000_0000_0000_0000, 24'd4);
      iss(7'o054, 3'd5, 6'd1, 64'h1, '0, '0);
      @(negedge clk);
      expv("coll", 1'b1, 64'h1234_5678_9ABC_DEFF, 3'd3);
      chk("coll_flag", {63'd0, o_collide}, 64'd1);
      @(negedge clk);
      expv("coll_drop", 1'b0, '0, '0);
      chk("coll_clr", {63'd0, o_collide}, 64'd0);
`else
      iss(7'o056, 3'd6, '0, si_pat, 64'hF000_0000_0000_0000, 24'd4);
      @(negedge clk);
      expv("nodbl_a", 1'b0, '0, '0);
      @(negedge clk);
      expv("nodbl_b", 1'b0, '0, '0);
      chk("nodbl_c", {63'd0, o_collide}, 64'd0);
`endif

      iss(7'o054, 3'd4, 6'd8, 64'hAB, '0, '0);
      @(negedge clk);
      expv("s054", 1'b1, 64'hAB00, 3'd4);
      iss(7'o043, 3'd5, 6'd8, '0, '0, '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_v", {63'd0, o_valid}, 64'd0);
      chk("mid_rst_r", o_result, 64'd0);
      chk("mid_rst_d", {61'd0, o_dest}, 64'd0);
      @(negedge clk);
      chk("mid_rst_v2", {63'd0, o_valid}, 64'd0);

      rst = 1'b1;
      iss(7'o042, 3'd2, 6'd0, '0, '0, '0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_iss_v", {63'd0, o_valid}, 64'd0);
      end

      for (int c = 0; c < 3000; c++) begin
         int sel;
         rst     = ($urandom_range(0, 199) == 0);
         i_issue = ($urandom_range(0, 3) != 0);
         i_instr = ops[$urandom_range(0, 9)];
         i_i     = 3'($urandom_range(0, 7));
         sel     = $urandom_range(0, 3);
         i_jk    = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63
                                     : 6'($urandom_range(0, 63));
         i_si    = {$urandom(), $urandom()};
         i_sj    = {$urandom(), $urandom()};
         sel     = $urandom_range(0, 5);
         case (sel)
            0: i_ak = 24'd0;
            1: i_ak = 24'd64;
            2: i_ak = 24'd127;
            3: i_ak = 24'd128;
            4: i_ak = 24'($urandom());
            default: i_ak = 24'($urandom_range(0, 127));
         endcase
         @(negedge clk);
      end
      rst = 1'b0;
      i_issue = 1'b0;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
